// File: rtl/dtt_xbar_pkg.sv
// Shared types and width helpers for the crossbar egress buffer.
package dtt_xbar_pkg;

    // Per-port FIFO occupancy state, derived from the registered count.
    typedef enum logic [1:0] {
        FifoEmpty,
        FifoPartial,
        FifoFull
    } fifo_state_e;

    // Pointer width able to index DEPTH entries (at least 1 bit).
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count width able to hold 0..DEPTH inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dtt_egress_fifo.sv
// One egress port: show-ahead FIFO with overflow drop counter and almost_full.
module dtt_egress_fifo
    import dtt_xbar_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned AFULL_THRESH = 6,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [DATA_WIDTH-1:0]       xb_data_i,
    input  logic                        xb_valid_i,
    output logic [DATA_WIDTH-1:0]       eg_data_o,
    output logic                        eg_valid_o,
    input  logic                        eg_ready_i,
    output logic                        almost_full_o,
    output logic [cnt_w(DEPTH)-1:0]     fill_level_o,
    output logic [CNT_WIDTH-1:0]        drop_cnt_o
);

    localparam int unsigned PtrW = ptr_w(DEPTH);
    localparam int unsigned CntW = cnt_w(DEPTH);
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
    localparam logic [CntW-1:0] AfullC = CntW'(AFULL_THRESH);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t           mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;
    fifo_state_e     state;
    logic            push, pop, drop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // Occupancy decode and handshake qualification.
    always_comb begin
        if (count_q == '0) begin
            state = FifoEmpty;
        end else if (count_q == DepthC) begin
            state = FifoFull;
        end else begin
            state = FifoPartial;
        end
        pop  = eg_valid_o & eg_ready_i;
        // A full FIFO still accepts a word when a pop frees a slot in the same cycle.
        push = xb_valid_i & ((state != FifoFull) | pop);
        drop = xb_valid_i & (state == FifoFull) & ~pop;
    end

    // Next-state for pointers, count and saturating drop counter.
    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        drop_d = drop_q;
        if (drop && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Storage write; contents are intentionally left uncleared by reset.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem_q[wr_ptr_q] <= xb_data_i;
        end
    end

    // Outputs depend only on registered state, so there is no xb-to-eg bypass.
    always_comb begin
        eg_valid_o    = (state != FifoEmpty);
        eg_data_o     = eg_valid_o ? mem_q[rd_ptr_q] : '0;
        almost_full_o = (count_q >= AfullC);
        fill_level_o  = count_q;
        drop_cnt_o    = drop_q;
    end

endmodule

// File: rtl/dtt_xbar_egress_buffer.sv
// Crossbar egress stage: one independent FIFO per crossbar output port.
module dtt_xbar_egress_buffer
    import dtt_xbar_pkg::*;
#(
    parameter int unsigned N_OUT        = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned AFULL_THRESH = 6,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [N_OUT-1:0][DATA_WIDTH-1:0]           xb_data_i,
    input  logic [N_OUT-1:0]                           xb_valid_i,
    output logic [N_OUT-1:0][DATA_WIDTH-1:0]           eg_data_o,
    output logic [N_OUT-1:0]                           eg_valid_o,
    input  logic [N_OUT-1:0]                           eg_ready_i,
    output logic [N_OUT-1:0]                           almost_full_o,
    output logic [N_OUT-1:0][$clog2(DEPTH+1)-1:0]      fill_level_o,
    output logic [N_OUT-1:0][CNT_WIDTH-1:0]            drop_cnt_o
);

    for (genvar p = 0; p < N_OUT; p++) begin : g_port
        dtt_egress_fifo #(
            .DATA_WIDTH  (DATA_WIDTH),
            .DEPTH       (DEPTH),
            .AFULL_THRESH(AFULL_THRESH),
            .CNT_WIDTH   (CNT_WIDTH)
        ) u_fifo (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .xb_data_i    (xb_data_i[p]),
            .xb_valid_i   (xb_valid_i[p]),
            .eg_data_o    (eg_data_o[p]),
            .eg_valid_o   (eg_valid_o[p]),
            .eg_ready_i   (eg_ready_i[p]),
            .almost_full_o(almost_full_o[p]),
            .fill_level_o (fill_level_o[p]),
            .drop_cnt_o   (drop_cnt_o[p])
        );
    end

endmodule
